// File: rtl/mem_pkg.sv
// Shared memory access types and the request legality check used by the load/store unit.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE_MEM_ACCESS = 2'b00,
    HALF_MEM_ACCESS = 2'b01,
    WORD_MEM_ACCESS = 2'b10
  } mem_access_t;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'b00,
    LSU_ACCESS = 2'b01,
    LSU_RESP   = 2'b10
  } lsu_state_t;

  // True when the size encoding is illegal or the address is not naturally aligned.
  function automatic logic access_error(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      BYTE_MEM_ACCESS: return 1'b0;
      HALF_MEM_ACCESS: return addr_lo[0];
      WORD_MEM_ACCESS: return addr_lo != 2'b00;
      default:         return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extender.sv
// Sign- or zero-extends a right-aligned BYTE/HALF load value to the full data width.
module load_extender
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  always_comb begin
    byte_s = data[7:0];
    half_s = data[15:0];
    ext    = data;
    case (size)
      BYTE_MEM_ACCESS: begin
        if (is_unsigned) ext = {{(DATA_WIDTH-8){1'b0}}, data[7:0]};
        else             ext = DATA_WIDTH'(byte_s);
      end
      HALF_MEM_ACCESS: begin
        if (is_unsigned) ext = {{(DATA_WIDTH-16){1'b0}}, data[15:0]};
        else             ext = DATA_WIDTH'(half_s);
      end
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one request at a time, runs a single memory cycle
// for legal requests and returns a registered, extended response.
module load_store_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic [1:0]            mem_access_type,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  lsu_state_t            state, state_nxt;
  logic                  write_p0, unsigned_p0;
  logic [1:0]            size_p0;
  logic [DATA_WIDTH-1:0] addr_p0, wdata_p0;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic                  err_p1;
  logic                  req_fire, req_bad;
  logic [DATA_WIDTH-1:0] load_ext;

  function automatic logic [DATA_WIDTH-1:0] mask_store(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [1:0] size);
    case (size)
      BYTE_MEM_ACCESS: return {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      HALF_MEM_ACCESS: return {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default:         return d;
    endcase
  endfunction

  assign req_fire = (state == LSU_IDLE) && req_valid;
  assign req_bad  = access_error(req_size, req_addr[1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LSU_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE:   if (req_valid) state_nxt = req_bad ? LSU_RESP : LSU_ACCESS;
      LSU_ACCESS: state_nxt = LSU_RESP;
      LSU_RESP:   if (rsp_ready) state_nxt = LSU_IDLE;
      default:    state_nxt = LSU_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == LSU_IDLE);
    rsp_valid = (state == LSU_RESP);
    mem_read  = (state == LSU_ACCESS) && !write_p0;
    mem_write = (state == LSU_ACCESS) && write_p0;
  end

  // p0: request latched on acceptance; these registers drive the memory port directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_p0    <= 1'b0;
      unsigned_p0 <= 1'b0;
      size_p0     <= WORD_MEM_ACCESS;
      addr_p0     <= '0;
      wdata_p0    <= '0;
    end else if (req_fire) begin
      write_p0    <= req_write;
      unsigned_p0 <= req_unsigned;
      size_p0     <= req_size;
      addr_p0     <= req_addr;
      wdata_p0    <= mask_store(req_wdata, req_size);
    end
  end

  load_extender #(.DATA_WIDTH(DATA_WIDTH)) u_load_extender (
    .data        (mem_data_out),
    .size        (size_p0),
    .is_unsigned (unsigned_p0),
    .ext         (load_ext)
  );

  // p1: response captured on error acceptance or at the closing edge of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else if (req_fire && req_bad) begin
      rdata_p1 <= '0;
      err_p1   <= 1'b1;
    end else if (state == LSU_ACCESS) begin
      rdata_p1 <= write_p0 ? '0 : load_ext;
      err_p1   <= 1'b0;
    end
  end

  assign rsp_rdata       = rdata_p1;
  assign rsp_err         = err_p1;
  assign mem_addr        = addr_p0;
  assign mem_data_in     = wdata_p0;
  assign mem_access_type = size_p0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory and a reference model.
module tb_load_store_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_write, mem_read;
  logic [1:0]  mem_access_type;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:255];
  logic [7:0] ref_mem [0:255];

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_write(mem_write), .mem_read(mem_read),
    .mem_access_type(mem_access_type), .mem_data_out(mem_data_out)
  );

  // Data memory: combinational read zero-extended by access type, write on rising edge.
  logic [7:0] ma, ma1, ma2, ma3;
  assign ma  = mem_addr[7:0];
  assign ma1 = ma + 8'd1;
  assign ma2 = ma + 8'd2;
  assign ma3 = ma + 8'd3;

  always_comb begin
    case (mem_access_type)
      2'b00:   mem_data_out = {24'h0, mem[ma]};
      2'b01:   mem_data_out = {16'h0, mem[ma1], mem[ma]};
      default: mem_data_out = {mem[ma3], mem[ma2], mem[ma1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma] <= mem_data_in[7:0];
      if (mem_access_type != 2'b00) mem[ma1] <= mem_data_in[15:8];
      if (mem_access_type == 2'b10) begin
        mem[ma2] <= mem_data_in[23:16];
        mem[ma3] <= mem_data_in[31:24];
      end
    end
  end

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int     n = 1 << sz;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[(a + i) % 256] = 8'(d >> (8 * i));
  endtask

  function automatic logic expect_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] expect_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return d % 256;
    if (sz == 2'b01) return d % 65536;
    return d;
  endfunction

  // One full request/response exchange; reports what the port showed along the way.
  task automatic do_txn(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int strobes, output logic [31:0] wd_seen,
                        output logic [31:0] addr_seen);
    wd_seen = 32'h0;
    addr_seen = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    strobes = 0;
    while (!rsp_valid && lat < 8) begin
      if (mem_read || mem_write) begin
        strobes++;
        wd_seen = mem_data_in;
        addr_seen = mem_addr;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (mem_read || mem_write) strobes++;
    rd = rsp_rdata;
    er = rsp_err;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: ready=%b valid=%b rdata=%h err=%b required 1/0/0/0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0 ||
        mem_data_in !== 32'h0 || mem_access_type !== 2'b10) begin
      errors++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h din=%h type=%b required 0/0/0/0/10",
               mem_read, mem_write, mem_addr, mem_data_in, mem_access_type);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_access_type !== 2'b10) begin
      errors++;
      $display("FAIL post_reset: ready=%b valid=%b type=%b required 1/0/10",
               req_ready, rsp_valid, mem_access_type);
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, wds, ads;
    logic er;
    int lat, st;
    do_txn(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, rd, er, lat, st, wds, ads);
    ref_store(32'h40, 2'b10, 32'hDEADBEEF);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat != 1 || st != 1 || wds !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL store_word: rdata=%h err=%b lat=%0d strobes=%0d din=%h required 0/0/1/1/deadbeef",
               rd, er, lat, st, wds);
    end
    do_txn(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, rd, er, lat, st, wds, ads);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 1 || st != 1 || ads !== 32'h40) begin
      errors++;
      $display("FAIL load_word: rdata=%h err=%b lat=%0d strobes=%0d addr=%h required deadbeef/0/1/1/40",
               rd, er, lat, st, ads);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, wds, ads;
    logic er;
    int lat, st;
    do_txn(1'b1, 2'b00, 1'b0, 32'h41, 32'h12345680, rd, er, lat, st, wds, ads);
    ref_store(32'h41, 2'b00, 32'h12345680);
    checks++;
    if (wds !== 32'h00000080 || er !== 1'b0 || st != 1) begin
      errors++;
      $display("FAIL store_byte: din=%h err=%b strobes=%0d required 00000080/0/1", wds, er, st);
    end
    do_txn(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, rd, er, lat, st, wds, ads);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_signed: rdata=%h err=%b required ffffff80/0", rd, er);
    end
    do_txn(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, rd, er, lat, st, wds, ads);
    checks++;
    if (rd !== 32'h00000080 || er !== 1'b0) begin
      errors++;
      $display("FAIL load_byte_unsigned: rdata=%h err=%b required 00000080/0", rd, er);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd, wds, ads;
    logic er;
    int lat, st;
    do_txn(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000A5A5, rd, er, lat, st, wds, ads);
    ref_store(32'h22, 2'b01, 32'h0000A5A5);
    do_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat, st, wds, ads);
    checks++;
    if (rd !== 32'hFFFFA5A5 || er !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL load_half_signed: rdata=%h err=%b lat=%0d required ffffa5a5/0/1", rd, er, lat);
    end
  endtask

  task automatic test_errors();
    logic [1:0]  sz_t [4] = '{2'b10, 2'b01, 2'b11, 2'b01};
    logic [31:0] a_t  [4] = '{32'h42, 32'h43, 32'h40, 32'h21};
    logic        w_t  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] rd, wds, ads;
    logic er;
    int lat, st;
    for (int i = 0; i < 4; i++) begin
      do_txn(w_t[i], sz_t[i], 1'b0, a_t[i], 32'hFFFFFFFF, rd, er, lat, st, wds, ads);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 0 || st != 0) begin
        errors++;
        $display("FAIL error_req%0d: err=%b rdata=%h lat=%0d strobes=%0d required 1/0/0/0",
                 i, er, rd, lat, st);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int st;
    exp = ref_load(32'h40, 2'b10, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b1;
    req_addr = 32'h40; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(posedge clk); #1;
    st = (mem_read || mem_write) ? 1 : 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (mem_read || mem_write) st++;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_resp%0d: valid=%b rdata=%h err=%b ready=%b required 1/%h/0/0",
                 c, rsp_valid, rsp_rdata, rsp_err, req_ready, exp);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || st != 1) begin
      errors++;
      $display("FAIL hold_release: ready=%b valid=%b strobes=%0d required 1/0/1", req_ready, rsp_valid, st);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_read !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL second_accept: mem_read=%b ready=%b required 1/0", mem_read, req_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp) begin
      errors++;
      $display("FAIL second_resp: valid=%b rdata=%h required 1/%h", rsp_valid, rsp_rdata, exp);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, wds, ads;
    logic er;
    int lat, st;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b1;
    req_addr = 32'h40; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobe: rd=%b wr=%b valid=%b required 0/0/0", mem_read, mem_write, rsp_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: ready=%b valid=%b required 1/0", req_ready, rsp_valid);
    end
    do_txn(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat, st, wds, ads);
    checks++;
    if (rd !== ref_load(32'h22, 2'b01, 1'b0) || er !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL abort_next_load: rdata=%h err=%b lat=%0d required %h/0/1",
               rd, er, lat, ref_load(32'h22, 2'b01, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wds, ads, a, wd, e_rd;
    logic er, w, u, e_err;
    logic [1:0] sz;
    int lat, st;
    for (int i = 0; i < 40; i++) begin
      w  = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom_range(0, 63) * 4 + (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
      wd = $urandom;
      e_err = expect_err(sz, a);
      e_rd  = (!w && !e_err) ? ref_load(a, sz, u) : 32'h0;
      do_txn(w, sz, u, a, wd, rd, er, lat, st, wds, ads);
      checks++;
      if (rd !== e_rd || er !== e_err || lat != (e_err ? 0 : 1) || st != (e_err ? 0 : 1)) begin
        errors++;
        $display("FAIL random%0d: w=%b sz=%b a=%h rdata=%h err=%b lat=%0d strobes=%0d required %h/%b",
                 i, w, sz, a, rd, er, lat, st, e_rd, e_err);
      end
      if (!e_err) begin
        checks++;
        if (ads !== a || (w && wds !== expect_wdata(sz, wd))) begin
          errors++;
          $display("FAIL random_port%0d: addr=%h din=%h required %h/%h",
                   i, ads, wds, a, expect_wdata(sz, wd));
        end
      end
      if (w && !e_err) ref_store(a, sz, wd);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0; rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the execute stage and the data `memory` block, driving its `addr`/`data_in`/`mem_write`/`mem_read`/`mem_access_type` port and consuming its combinational `data_out`. It accepts one load or store request per valid/ready handshake and checks size and alignment. Store data is masked to the access size. It runs exactly one memory cycle per legal request and returns a registered response. Load data is sign-extended or zero-extended. Misaligned or illegal requests are answered with an error and never reach memory.

## Interface
- `DATA_WIDTH`, 32, width of address and data paths.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2 (`mem_access_t`): BYTE/HALF/WORD; encoding 2'b11 is illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in DATA_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out DATA_WIDTH: extended load data; 0 for stores and errors.
- `rsp_err` out 1: misaligned address or illegal size.
- `mem_addr` out DATA_WIDTH: to memory `addr`.
- `mem_data_in` out DATA_WIDTH: to memory `data_in`.
- `mem_write` out 1: to memory `mem_write`.
- `mem_read` out 1: to memory `mem_read`.
- `mem_access_type` out 2: to memory `mem_access_type`.
- `mem_data_out` in DATA_WIDTH: from memory `data_out`, zero-extended by memory for HALF/BYTE.

## Operation
- FSM states are IDLE (reset state), ACCESS and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch write, size, unsigned, addr and wdata.
  - An error is flagged for: HALF with addr[0]=1; WORD with addr[1:0]≠0; size 2'b11.
  - Error: go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No memory strobe is issued.
  - Otherwise: go to ACCESS.
- **ACCESS** (exactly one cycle)
  - `mem_read` or `mem_write` is high, all driven from the latched registers.
  - `mem_data_in` = wdata masked to size: BYTE keeps [7:0], HALF keeps [15:0], all other bits 0.
  - Load: at the closing edge, `rsp_rdata` ← extended `mem_data_out`.
    - BYTE signed: bit 7 replicated. HALF signed: bit 15 replicated. Unsigned: zero upper bits. WORD: passed through.
  - Store: `rsp_rdata` ← 0.
  - Go to RESP with `rsp_err`=0.
- **RESP**
  - `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable.
  - On `rsp_ready`, go to IDLE. `rsp_ready` while `rsp_valid`=0 is ignored.
- Outside ACCESS: `mem_read`=`mem_write`=0. `mem_addr`, `mem_data_in` and `mem_access_type` hold their last values.

## Timing
- Request accepted at edge E0.
  - Legal request: ACCESS during E0→E1; store commits in memory at E1; `rsp_valid` high from E1.
  - Error: `rsp_valid` high from E0.
- Response handshake completes at edge E2 when `rsp_ready`=1. `req_ready` is high from E2.
- Peak throughput is one request per 3 cycles. No request is accepted in ACCESS or RESP.
- Values while `rst` is high and after release:
  - State IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_data_in`=0, `mem_access_type`=WORD.
- Reset in ACCESS aborts the strobe immediately, since it is asynchronous. A store whose edge coincides with reset assertion is not guaranteed.
- Reset in RESP drops the pending response with no handshake.
- `req_valid` held through RESP is not consumed until the next IDLE cycle.

## Structure
- Shared package `mem_pkg`:
  - `mem_access_t` enum: BYTE_MEM_ACCESS=2'b00, HALF_MEM_ACCESS=2'b01, WORD_MEM_ACCESS=2'b10. The `memory` block already uses these names.
  - `lsu_state_t` enum.
  - Misalignment check function.
- One combinational sub-module, `load_extender`:
  - Inputs: data, size, unsigned.
  - Output: extended DATA_WIDTH value.
  - Reused later by any bypass path.

## Test plan
- Reset, then store WORD 0xDEADBEEF @0x40, then load WORD unsigned @0x40 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` exactly 1 cycle after acceptance.
- Store BYTE 0x12345680 @0x41, then load BYTE @0x41: signed → 0xFFFFFF80, unsigned → 0x00000080; `mem_data_in` during the store = 0x00000080.
- Store HALF 0x0000A5A5 @0x22, then load HALF signed → 0xFFFFA5A5.
- Load WORD @0x42, load HALF @0x43, and a request with size 2'b11 → each `rsp_err`=1 with `rsp_valid` in the cycle after acceptance; `mem_read`/`mem_write` never asserted.
- Hold `rsp_ready`=0 for 4 cycles with `req_valid` held high → `rsp_valid`, `rsp_rdata` and `rsp_err` stable, `req_ready`=0, no second memory access; request accepted in the first IDLE cycle after the handshake.
- Assert `rst` mid-ACCESS of a load → `mem_read` falls in the same cycle, `rsp_valid`=0, `req_ready`=1 after release; the next load returns correct data.
